// File: rtl/data_mem_lsu.sv
// Single-port data memory with a load/store unit front end: one access at a time,
// programmable wait latency, byte/half/word accesses with sign or zero extension.
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  logic [AW-1:0] idx;
  logic          accept;
  logic          acc_err;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wd;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic          unused_addr_bits;

  assign idx              = a[AW+1:2];
  assign unused_addr_bits = ^a[31:AW+2];
  assign accept           = (state == S_IDLE) && req;
  assign busy             = (state != S_IDLE);

  // Lane enables and replicated store data for the request on the inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_err = 1'b0;
    lane_be = 4'b0000;
    lane_wd = wd;
    case (size[1:0])
      2'b00: begin
        lane_be = 4'b0001 << a[1:0];
        lane_wd = {4{wd[7:0]}};
      end
      2'b01: begin
        lane_be = a[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{wd[15:0]}};
        acc_err = a[0];
      end
      2'b10: begin
        lane_be = 4'b1111;
        acc_err = (a[1:0] != 2'b00) || size[2];
      end
      default: acc_err = 1'b1;
    endcase
  end

  // NOTE: the array has no reset; stores must survive rst_n and a reset term would block RAM inference.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (we && !acc_err) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_be[i]) mem[idx][8*i +: 8] <= lane_wd[8*i +: 8];
        end
      end
      rdata_q <= mem[idx];
    end
  end

  // Loads format the word captured on the accept edge using the latched size/offset.
  always_comb begin
    shifted   = rdata_q >> {off_q, 3'b000};
    load_data = rdata_q;
    case (size_q[1:0])
      2'b00:   load_data = {{24{~size_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~size_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      we_q   <= 1'b0;
      size_q <= 3'b000;
      off_q  <= 2'b00;
      err_q  <= 1'b0;
      ready  <= 1'b0;
      err    <= 1'b0;
      rd     <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ready <= 1'b0;
      err   <= 1'b0;
      rd    <= 32'h0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q   <= we;
            size_q <= size;
            off_q  <= a[1:0];
            err_q  <= acc_err;
            if (LATENCY == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == LAT4) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b1;
          err   <= err_q;
          rd    <= (err_q || we_q) ? 32'h0 : load_data;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: three instances (LATENCY 0, 1, 3) driven with
// directed and random accesses against a byte-array reference model.
module tb_data_mem_lsu;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  size;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        busy;

    bit          done = 1'b0;
    bit          acc_valid = 1'b0;
    int          acc_cyc = 0;
    exp_t        exp_q[$];
    logic [7:0]  mb [DEPTH*4];

    data_mem_lsu #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (L),
      .INIT_ZERO  (1'b1)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .we   (we),
      .size (size),
      .a    (a),
      .wd   (wd),
      .rd   (rd),
      .ready(ready),
      .err  (err),
      .busy (busy)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      check($sformatf("L%0d_%s", L, n), act, exp);
    endtask

    // Byte-addressed little-endian memory; applies stores and returns the expected response.
    function automatic exp_t model(input bit w, input logic [2:0] s,
                                   input logic [31:0] addr, input logic [31:0] data);
      exp_t        r;
      int          nb;
      bit          sgn;
      int          base;
      logic [31:0] v;
      r.rd  = 32'h0;
      r.err = 1'b0;
      r.due = 0;
      nb    = 0;
      sgn   = 1'b0;
      v     = 32'h0;
      base  = int'(addr % 32'(DEPTH*4));
      case (s)
        3'b000: begin nb = 1; sgn = 1'b1; end
        3'b001: begin nb = 2; sgn = 1'b1; end
        3'b010: nb = 4;
        3'b100: nb = 1;
        3'b101: nb = 2;
        default: nb = 0;
      endcase
      if (nb == 0 || (base % nb) != 0) begin
        r.err = 1'b1;
        return r;
      end
      if (w) begin
        for (int i = 0; i < nb; i++) mb[base+i] = data[8*i +: 8];
        return r;
      end
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base+i];
      for (int b = 8*nb; b < 32; b++) v[b] = sgn & v[8*nb-1];
      r.rd = v;
      return r;
    endfunction

    task automatic noise();
      req  = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      size = 3'($urandom_range(0, 7));
      a    = $urandom;
      wd   = $urandom;
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle (or just out of reset).
    task automatic issue(input bit w, input logic [2:0] s, input logic [31:0] addr,
                         input logic [31:0] data, input int abort_k);
      exp_t e;
      int   guard = 0;
      while (busy && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (busy) chk("busy_stuck", 32'(busy), 32'd0);
      req  = 1'b1;
      we   = w;
      size = s;
      a    = addr;
      wd   = data;
      e = model(w, s, addr, data);
      e.due = cyc + L + 2;
      exp_q.push_back(e);
      acc_valid = 1'b1;
      acc_cyc   = cyc + 1;
      @(posedge clk);
      if (abort_k >= 0) begin
        repeat (abort_k) @(posedge clk);
        #1 rst_n = 1'b0;
        void'(exp_q.pop_back());
        acc_valid = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_rd", rd, 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;
      end else begin
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
          noise();
          @(negedge clk);
          guard++;
        end
        req = 1'b0;
      end
    endtask

    // Monitor: busy against the accept history, every READY pulse against the scoreboard.
    always @(negedge clk) begin
      exp_t e;
      chk("busy", 32'(busy), 32'(acc_valid && cyc >= acc_cyc && cyc <= acc_cyc + L));
      if (ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ready", 32'(ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(e.due));
          chk("rd", rd, e.rd);
          chk("err", 32'(err), 32'(e.err));
        end
      end else begin
        chk("idle_rd", rd, 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
          chk("ready_missing", 32'(ready), 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end

    initial begin
      int guard;
      logic [31:0] r;
      rst_n = 1'b0;
      noise();
      req = 1'b0;
      foreach (mb[i]) mb[i] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rd", rd, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1'b1, 3'b010, 32'h8, 32'hFFFF_FFFF, -1);
      issue(1'b0, 3'b010, 32'h8, 32'h0, -1);
      issue(1'b1, 3'b010, 32'h8, 32'h0, -1);
      issue(1'b1, 3'b000, 32'h9, 32'h0000_0080, -1);
      issue(1'b0, 3'b000, 32'h9, 32'h0, -1);
      issue(1'b0, 3'b100, 32'h9, 32'h0, -1);
      issue(1'b0, 3'b010, 32'h8, 32'h0, -1);
      issue(1'b1, 3'b001, 32'h3, 32'hABCD_1234, -1);
      issue(1'b0, 3'b010, 32'h0, 32'h0, -1);
      issue(1'b1, 3'b010, 32'h400, 32'h1234_5678, -1);
      issue(1'b0, 3'b010, 32'h0, 32'h0, -1);
      issue(1'b0, 3'b101, 32'h2, 32'h0, -1);
      issue(1'b0, 3'b001, 32'h0, 32'h0, -1);
      issue(1'b0, 3'b011, 32'h0, 32'h0, -1);
      issue(1'b0, 3'b110, 32'h0, 32'h0, -1);
      issue(1'b0, 3'b010, 32'h0, 32'h0, (L < 2) ? L : 2);
      issue(1'b0, 3'b010, 32'h0, 32'h0, -1);

      for (int n = 0; n < 150; n++) begin
        r = $urandom & 32'hFFFF_FC1F;
        issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r, $urandom,
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, L)) : -1);
      end

      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int c = 0;
    while (c < 60000 && !(g_inst[0].done && g_inst[1].done && g_inst[2].done)) begin
      @(posedge clk);
      c++;
    end
    check("all_done", 32'({g_inst[0].done, g_inst[1].done, g_inst[2].done}), 32'h7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words; SHALL be a power of two, 4..65536.
REQ-002 Parameter LATENCY, default 1, wait cycles inserted before completion; SHALL be 0..15.
REQ-003 Parameter INIT_ZERO, default 1, when 1 the memory array SHALL be zero at time 0 (simulation init only, not on reset).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 REQ  input  1  access request, sampled only in IDLE.
REQ-007 WE  input  1  1 = store, 0 = load; sampled with REQ.
REQ-008 SIZE  input  3  access type: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; sampled with REQ.
REQ-009 A  input  32  byte address; sampled with REQ.
REQ-010 WD  input  32  store data, low bytes used for byte/half; sampled with REQ.
REQ-011 RD  output  32  load result, valid while READY=1.
REQ-012 READY  output  1  one-cycle completion pulse.
REQ-013 ERR  output  1  access rejected; valid while READY=1.
REQ-014 BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, WAIT, RESP; IDLE->WAIT on REQ=1 when LATENCY>0, IDLE->RESP on REQ=1 when LATENCY=0, WAIT->RESP when wait counter reaches LATENCY, RESP->IDLE unconditionally.
REQ-016 Accept edge = rising edge in IDLE with REQ=1; A, WE, SIZE, WD SHALL be latched there; later input changes SHALL not affect the access.
REQ-017 READY SHALL be high exactly one cycle, beginning LATENCY+1 cycles after the accept edge.
REQ-018 REQ SHALL be ignored in WAIT and RESP; no queuing; minimum spacing between accepts = LATENCY+2 cycles.
REQ-019 Word index = A[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (address wraps modulo 4*DEPTH_WORDS).
REQ-020 Misaligned = half with A[0]=1, or word with A[1:0]!=00; SIZE values 011, 110, 111 SHALL be illegal.
REQ-021 Misaligned or illegal access: no memory write, RD=0, ERR=1 with READY.
REQ-022 Legal store: byte lanes selected by A[1:0] and SIZE written on the accept edge; other lanes unchanged; RD=0 at READY.
REQ-023 Legal load: RD = selected byte/half shifted to bit 0, sign-extended (000, 001) or zero-extended (100, 101); word returned unchanged.
REQ-024 Load data SHALL reflect memory contents at the accept edge.
REQ-025 RD and ERR SHALL be 0 whenever READY=0.

Reset
REQ-026 RST_N=0 SHALL immediately force state IDLE, wait counter 0, READY=0, ERR=0, BUSY=0, RD=0.
REQ-027 Memory array SHALL not be cleared by reset; a store committed on an accept edge before reset SHALL persist.
REQ-028 Reset during WAIT or RESP SHALL abort the access with no READY pulse; first accept possible on the first rising edge with RST_N=1 after release.

Verification
REQ-029 LATENCY=1: store word A=0x8, WD=0xFFFFFFFF; READY 2 cycles after accept, ERR=0; load word A=0x8 -> RD=0xFFFFFFFF.
REQ-030 Store byte A=0x9, WD=0x00000080 over word 0x00000000; load byte signed A=0x9 -> RD=0xFFFFFF80; unsigned -> 0x00000080; load word A=0x8 -> 0x00008000.
REQ-031 Store half A=0x3 -> READY with ERR=1, RD=0; load word A=0x0 shows word 0 unchanged.
REQ-032 DEPTH_WORDS=256: store word A=0x400, WD=0x12345678; load word A=0x0 -> 0x12345678 (wrap).
REQ-033 LATENCY=3: RST_N pulsed low 2 cycles after accept of a load -> no READY, BUSY=0 immediately; REQ held high during WAIT of a second access not accepted.
REQ-034 LATENCY=0: accept on cycle N -> READY on cycle N+1 only; REQ held continuously -> accepts every 2 cycles.
